// File: rtl/adc_capture_sequencer.sv
// Frame-capture controller for a 12-bit SPI ADC: paced CONVST, conversion wait,
// SPI transfer (config word out, sample in), then one buffer write per sample.
module adc_capture_sequencer #(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int NUM_SAMPLES   = 128,
    parameter int ADDR_W        = 7
) (
    input  logic              ref_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        channel,
    input  logic              spi_sdo,
    output logic              spi_sdi,
    output logic              spi_scl,
    output logic              CONVST,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       data,
    output logic              busy,
    output logic              ready,
    output logic [2:0]        o_currentState
);
    // state | meaning
    // IDLE  | after reset, waiting for start
    // CONV  | CONVST high for 2 cycles, sample period restarts
    // WAIT  | ADC conversion time
    // SHIFT | 12 SCL periods: config out on sdi, sample in on sdo
    // STORE | one-cycle buffer write
    // PACE  | hold off until the sample period has elapsed
    // DONE  | frame complete, waiting for start
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CONV  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] STORE = 3'd4;
    localparam logic [2:0] PACE  = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam int TMIN = CONV_CYCLES + 24 * CLK_DIV + 4;
    localparam int PMAX = (SAMPLE_PERIOD > TMIN) ? SAMPLE_PERIOD : TMIN;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int CMAX = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
    localparam int CW   = $clog2(CMAX + 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [2:0]        ch_q, ch_d;
    logic [PW-1:0]     per_q, per_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [11:0]       sh_q, sh_d;
    logic              scl_q, scl_d;
    logic              sdi_q, sdi_d;
    logic              convst_q, convst_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       data_q, data_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic [11:0]       cfg_word;

    // Config word bits: S/D, O/S, S1, S0, UNI, SLP, then six don't-care zeros.
    assign cfg_word = {1'b1, ch_q[0], ch_q[2], ch_q[1], 1'b1, 1'b0, 6'b0};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        per_d   = (state_q == IDLE || state_q == DONE) ? per_q : per_q + PW'(1);
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        scl_d   = scl_q;
        sdi_d   = sdi_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CONV;
                    ch_d    = channel;
                    idx_d   = '0;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            end
            CONV: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(CONV_CYCLES - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    scl_d   = 1'b0;
                    sdi_d   = cfg_word[11];
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    scl_d = ~scl_q;
                    if (!scl_q) begin
                        sh_d = {sh_q[10:0], spi_sdo};
                    end else if (bit_q == 4'd11) begin
                        state_d = STORE;
                        sdi_d   = 1'b0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        sdi_d = cfg_word[4'd10 - bit_q];
                    end
                end
            end
            STORE: begin
                if (idx_q == ADDR_W'(NUM_SAMPLES - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = PACE;
                end
            end
            PACE: begin
                // >= rather than == lets a too-short period fall back to the minimum.
                if (per_q >= PW'(SAMPLE_PERIOD - 1)) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        convst_d = (state_d == CONV);
        wr_d     = (state_d == STORE);
        busy_d   = (state_d == CONV) || (state_d == WAIT) || (state_d == SHIFT) ||
                   (state_d == STORE) || (state_d == PACE);
        ready_d  = (state_d == DONE);
        if (state_d == STORE) begin
            addr_d = idx_q;
            data_d = sh_q;
        end
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ch_q     <= '0;
            per_q    <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            scl_q    <= 1'b0;
            sdi_q    <= 1'b0;
            convst_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ch_q     <= ch_d;
            per_q    <= per_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            scl_q    <= scl_d;
            sdi_q    <= sdi_d;
            convst_q <= convst_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign spi_sdi        = sdi_q;
    assign spi_scl        = scl_q;
    assign CONVST         = convst_q;
    assign wr_en          = wr_q;
    assign addr           = addr_q;
    assign data           = data_q;
    assign busy           = busy_q;
    assign ready          = ready_q;
    assign o_currentState = state_q;
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: two instances (normal pacing and period underrun)
// share stimulus; each has an ADC model and a scoreboard monitor on its buffer writes.
module tb_adc_capture_sequencer;
    logic ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    logic        reset_n;
    logic        start;
    logic [2:0]  channel;
    logic [11:0] key;
    int          checks = 0;
    int          errors = 0;

    logic [11:0] tab [4] = '{12'h001, 12'h7FF, 12'h800, 12'hFFF};
    logic [30:0] exp0 [$];
    logic [30:0] exp1 [$];

    logic [1:0]  rdy_v, busy_v;
    logic [5:0]  st_v;
    logic [55:0] outs_v;
    logic [15:0] wr_cnt_v, wr_rst_v;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int SP    = (g == 0) ? 200 : 20;
        localparam int EXP_P = (g == 0) ? 200 : 62;
        logic        sdo = 1'b0;
        logic        sdi, scl, conv, wr, busy, ready;
        logic [6:0]  addr;
        logic [11:0] data;
        logic [2:0]  st;

        adc_capture_sequencer #(
            .CLK_DIV(2), .CONV_CYCLES(10), .SAMPLE_PERIOD(SP), .NUM_SAMPLES(4), .ADDR_W(7)
        ) dut (
            .ref_clk(ref_clk), .reset_n(reset_n), .start(start), .channel(channel),
            .spi_sdo(sdo), .spi_sdi(sdi), .spi_scl(scl), .CONVST(conv), .wr_en(wr),
            .addr(addr), .data(data), .busy(busy), .ready(ready), .o_currentState(st)
        );

        int          lcyc = 0, t_rise = 0, conv_run = 0, hi_run = 0, lo_run = 0;
        int          rises = 0, bad = 0, shlen = 0, fc = 0, bn = 0, wr_cnt = 0, wr_rst = 0;
        logic [11:0] word = '0, sdi_w = '0;
        logic        pconv = 1'b0, pscl = 1'b0, post = 1'b0, fin = 1'b0, have = 1'b0;
        logic [30:0] e;

        assign rdy_v[g]            = ready;
        assign busy_v[g]           = busy;
        assign st_v[g*3 +: 3]      = st;
        assign outs_v[g*28 +: 28]  = {conv, scl, sdi, wr, addr, data, busy, ready, st};
        assign wr_cnt_v[g*8 +: 8]  = wr_cnt[7:0];
        assign wr_rst_v[g*8 +: 8]  = wr_rst[7:0];

        always @(negedge ref_clk) begin
            lcyc++;
            if (!reset_n) begin
                if (wr) wr_rst++;
                rises = 0; bad = 0; shlen = 0; hi_run = 0; lo_run = 0; post = 1'b0; sdi_w = '0;
            end
            if (post) begin
                chk($sformatf("u%0d_wr_pulse", g), 32'(wr), 32'd0);
                if (fin) chk($sformatf("u%0d_ready_after_last", g), {ready, busy}, 2'b10);
                post = 1'b0;
            end
            if (st == 3'd0 || st == 3'd6) fc = 0;
            // ADC model: first bit valid from CONVST, next bit after every SCL fall
            if (conv && !pconv) begin
                if (fc > 0) chk($sformatf("u%0d_convst_spacing", g), lcyc - t_rise, EXP_P);
                t_rise = lcyc; conv_run = 1;
                word = tab[fc % 4] ^ key; fc++; bn = 0; sdo = word[11];
            end else if (conv) begin
                conv_run++;
            end else if (pconv) begin
                chk($sformatf("u%0d_convst_width", g), conv_run, 2);
            end
            pconv = conv;
            if (st == 3'd3) shlen++;
            if (scl && !pscl) begin
                rises++;
                sdi_w = {sdi_w[10:0], sdi};
                if (lo_run != 2) bad++;
                lo_run = 0; hi_run = 1;
            end else if (scl) begin
                hi_run++;
            end else begin
                if (pscl) begin
                    if (hi_run != 2) bad++;
                    bn++;
                    if (bn < 12) sdo = word[11 - bn];
                end
                if (st == 3'd3) lo_run++;
            end
            pscl = scl;
            if (wr && reset_n) begin
                have = 1'b0;
                if (g == 0 && exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
                if (g == 1 && exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
                if (!have) begin
                    chk($sformatf("u%0d_unexpected_wr", g), 32'(addr), 32'hFFFF);
                end else begin
                    chk($sformatf("u%0d_addr", g), 32'(addr), 32'(e[18:12]));
                    chk($sformatf("u%0d_data", g), 32'(data), 32'(e[11:0]));
                    chk($sformatf("u%0d_sdi_cfg", g), 32'(sdi_w), 32'(e[30:19]));
                    chk($sformatf("u%0d_scl_rises", g), rises, 12);
                    chk($sformatf("u%0d_scl_shape", g), bad, 0);
                    chk($sformatf("u%0d_shift_len", g), shlen, 48);
                    chk($sformatf("u%0d_flags_at_store", g), {busy, ready}, 2'b10);
                end
                wr_cnt++;
                post = 1'b1;
                fin = (addr == 7'd3);
                rises = 0; bad = 0; shlen = 0; lo_run = 0; sdi_w = '0;
            end
        end
    end

    task automatic push(input int g, input logic [11:0] cfg, input int i);
        logic [30:0] ent;
        ent = {cfg, 7'(i), tab[i] ^ key};
        if (g == 0) exp0.push_back(ent);
        else exp1.push_back(ent);
    endtask

    task automatic start_frame(input logic [2:0] ch, input logic [11:0] k, input logic [11:0] cfg,
                               input int na, input int nb);
        key = k;
        for (int i = 0; i < na; i++) push(0, cfg, i);
        for (int i = 0; i < nb; i++) push(1, cfg, i);
        @(negedge ref_clk);
        channel = ch;
        start   = 1'b1;
        @(negedge ref_clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int bound);
        int n = 0, gaps = 0;
        while (rdy_v != 2'b11 && n < bound) begin
            @(negedge ref_clk);
            n++;
            for (int g = 0; g < 2; g++) if (!rdy_v[g] && !busy_v[g]) gaps++;
        end
        chk({nm, "_timeout"}, 32'(n < bound), 32'd1);
        chk({nm, "_busy_gap"}, gaps, 0);
        chk({nm, "_done_flags"}, {rdy_v, busy_v}, 4'b1100);
    endtask

    task automatic wait_state(input int g, input logic [2:0] s, input int bound);
        int n = 0;
        while (st_v[g*3 +: 3] != s && n < bound) begin
            @(negedge ref_clk);
            n++;
        end
        chk($sformatf("wait_state%0d_timeout", s), 32'(n < bound), 32'd1);
    endtask

    initial begin
        int base;
        reset_n = 1'b1; start = 1'b0; channel = 3'd0; key = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset_outs_u0", 32'(outs_v[27:0]), 32'd0);
        chk("reset_outs_u1", 32'(outs_v[55:28]), 32'd0);
        repeat (3) @(negedge ref_clk);
        reset_n = 1'b1;
        repeat (4) @(negedge ref_clk);
        chk("idle_outs_u0", 32'(outs_v[27:0]), 32'd0);
        chk("idle_outs_u1", 32'(outs_v[55:28]), 32'd0);

        // channel 5 -> config 1,1,1,0,1,0; first sample 0x001^0xA5D = 0xA5C
        start_frame(3'd5, 12'hA5D, 12'hE80, 4, 4);
        wait_done("frame1", 1500);

        // start pulsed mid-SHIFT with another channel must be ignored
        start_frame(3'd2, 12'h000, 12'h980, 4, 4);
        wait_state(0, 3'd3, 100);
        @(negedge ref_clk);
        channel = 3'd7; start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
        chk("start_ignored_state", 32'(st_v), {26'd0, 3'd3, 3'd3});
        wait_done("frame2", 1500);

        // start held in DONE re-arms with the new channel
        key = 12'h123;
        for (int i = 0; i < 4; i++) begin push(0, 12'hB80, i); push(1, 12'hB80, i); end
        @(negedge ref_clk);
        channel = 3'd6; start = 1'b1;
        @(negedge ref_clk);
        chk("rearm_flags", {rdy_v, busy_v, st_v}, {2'b00, 2'b11, 3'd1, 3'd1});
        start = 1'b0;
        wait_done("frame3", 1500);

        // reset during the third SHIFT of the paced instance
        base = int'(wr_cnt_v[7:0]);
        start_frame(3'd3, 12'h0F0, 12'hD80, 2, 4);
        for (int n = 0; n < 1000 && int'(wr_cnt_v[7:0]) != base + 2; n++) @(negedge ref_clk);
        chk("frame4_two_writes", 32'(wr_cnt_v[7:0]), 32'(base + 2));
        wait_state(0, 3'd3, 500);
        #2 reset_n = 1'b0;
        #1;
        chk("midshift_reset_u0", 32'(outs_v[27:0]), 32'd0);
        chk("midshift_reset_u1", 32'(outs_v[55:28]), 32'd0);
        repeat (3) @(negedge ref_clk);
        reset_n = 1'b1;
        chk("wr_during_reset", 32'(wr_rst_v), 32'd0);
        @(negedge ref_clk);
        chk("post_reset_state", 32'(st_v), 32'd0);

        start_frame(3'd1, 12'h000, 12'hC80, 4, 4);
        wait_done("frame5", 1500);

        chk("queue_u0_empty", exp0.size(), 0);
        chk("queue_u1_empty", exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
